// File: rtl/mac_se_pkg.sv
// Shared constants and types for the Mac-style framebuffer path: CRT timing,
// framebuffer geometry and the read-return tag carried alongside each RAM read.
package mac_se_pkg;

  // Horizontal timing in pixels: active / front porch / sync / back porch.
  localparam int H_ACTIVE = 512;
  localparam int H_FRONT  = 24;
  localparam int H_SYNC   = 64;
  localparam int H_BACK   = 120;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing in lines: active / front porch / sync / back porch.
  localparam int V_ACTIVE = 342;
  localparam int V_FRONT  = 1;
  localparam int V_SYNC   = 3;
  localparam int V_BACK   = 38;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int PIX_PER_WORD = 16;
  localparam int ADDR_W       = 14;
  localparam int DATA_W       = 16;
  localparam int FB_WORDS     = (H_ACTIVE * V_ACTIVE) / PIX_PER_WORD;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int VID_DEADLINE_DEF = 12;

  typedef enum logic {
    SRC_VID  = 1'b0,
    SRC_HOST = 1'b1
  } src_e;

  typedef struct packed {
    logic valid;
    src_e src;
    logic oor;
  } ret_tag_t;

  // Counter width able to hold 0..limit, never zero bits wide.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/mac_se_fb_read_return.sv
// Read-return path: two-stage tag pipeline that follows each RAM read, then
// routes the sampled RAM word to the video or host return registers.
module mac_se_fb_read_return #(
  parameter int DATA_W = mac_se_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  mac_se_pkg::ret_tag_t tag_in,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 vid_rvalid,
  output logic [DATA_W-1:0]    vid_rdata,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata
);
  import mac_se_pkg::*;

  ret_tag_t tag_s1;
  ret_tag_t tag_s2;
  logic     ret_vid;
  logic     ret_host;
  logic [DATA_W-1:0] ret_data;

  always_comb begin
    ret_vid  = tag_s2.valid && (tag_s2.src == SRC_VID);
    ret_host = tag_s2.valid && (tag_s2.src == SRC_HOST);
    // Out-of-range reads never touched the RAM, so they return zero.
    ret_data = tag_s2.oor ? '0 : mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_s1      <= '0;
      tag_s2      <= '0;
      vid_rvalid  <= 1'b0;
      vid_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      tag_s1      <= tag_in;
      tag_s2      <= tag_s1;
      vid_rvalid  <= ret_vid;
      host_rvalid <= ret_host;
      if (ret_vid) begin
        vid_rdata <= ret_data;
      end
      if (ret_host) begin
        host_rdata <= ret_data;
      end
    end
  end

endmodule

// File: rtl/mac_se_fb_arbiter.sv
// Single-port framebuffer arbiter: video scan-out has priority, the host port
// wins once after waiting STARVE_LIMIT cycles; RAM controls are registered.
module mac_se_fb_arbiter #(
  parameter int ADDR_W       = mac_se_pkg::ADDR_W,
  parameter int DATA_W       = mac_se_pkg::DATA_W,
  parameter int FB_WORDS     = mac_se_pkg::FB_WORDS,
  parameter int STARVE_LIMIT = mac_se_pkg::STARVE_LIMIT_DEF,
  parameter int VID_DEADLINE = mac_se_pkg::VID_DEADLINE_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              vid_underrun,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mac_se_pkg::*;

  localparam int HW = cnt_w(STARVE_LIMIT);
  localparam int VW = cnt_w(VID_DEADLINE);

  logic [HW-1:0] host_wait;
  logic [HW-1:0] host_wait_nxt;
  logic [VW-1:0] vid_wait;
  logic [VW-1:0] vid_wait_nxt;
  logic          host_starved;
  logic          host_xfer;
  logic          host_oor;
  ret_tag_t      issue_tag;

  // Handshakes: video holds vid_req (and a stable vid_addr) until vid_ack;
  // a host beat transfers in any cycle where host_valid && host_ready. Both
  // grants are combinational, mutually exclusive, and forced low in reset.
  always_comb begin
    host_starved = (host_wait == HW'(STARVE_LIMIT));
    vid_ack      = !reset && vid_req && !(host_valid && host_starved);
    host_ready   = !reset && host_valid && !vid_ack;
    host_xfer    = host_valid && host_ready;
    host_oor     = (32'(host_addr) >= 32'(FB_WORDS));

    issue_tag.valid = vid_ack || (host_xfer && !host_we);
    issue_tag.src   = vid_ack ? SRC_VID : SRC_HOST;
    issue_tag.oor   = !vid_ack && host_oor;

    host_wait_nxt = '0;
    if (host_valid && !host_ready) begin
      host_wait_nxt = host_starved ? host_wait : host_wait + HW'(1);
    end

    vid_wait_nxt = '0;
    if (vid_req && !vid_ack) begin
      vid_wait_nxt = (vid_wait == VW'(VID_DEADLINE)) ? vid_wait : vid_wait + VW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      host_err     <= 1'b0;
      host_wait    <= '0;
      vid_wait     <= '0;
      vid_underrun <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      host_err  <= 1'b0;
      host_wait <= host_wait_nxt;
      vid_wait  <= vid_wait_nxt;
      if (vid_wait_nxt == VW'(VID_DEADLINE)) begin
        vid_underrun <= 1'b1;
      end
      if (vid_ack) begin
        mem_en   <= 1'b1;
        mem_addr <= vid_addr;
      end else if (host_xfer) begin
        // Out-of-range host beats are flagged and never reach the RAM.
        if (host_oor) begin
          host_err <= 1'b1;
        end else begin
          mem_en    <= 1'b1;
          mem_we    <= host_we;
          mem_addr  <= host_addr;
          mem_wdata <= host_wdata;
        end
      end
    end
  end

  mac_se_fb_read_return #(
    .DATA_W (DATA_W)
  ) u_read_return (
    .clk         (clk_in),
    .reset       (reset),
    .tag_in      (issue_tag),
    .mem_rdata   (mem_rdata),
    .vid_rvalid  (vid_rvalid),
    .vid_rdata   (vid_rdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata)
  );

endmodule

// File: tb/tb_mac_se_fb_arbiter.sv
// Directed bench for mac_se_fb_arbiter with a behavioural single-port RAM;
// a second instance built with STARVE_LIMIT=0 exercises the underrun flag.
module tb_mac_se_fb_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              vid_ack, vid_rvalid, host_ready, host_rvalid, host_err, vid_underrun;
  logic [DATA_W-1:0] vid_rdata, host_rdata, mem_wdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  logic              u0_vid_ack, u0_vid_rvalid, u0_host_ready, u0_host_rvalid, u0_host_err;
  logic              u0_vid_underrun, u0_mem_en, u0_mem_we;
  logic [DATA_W-1:0] u0_vid_rdata, u0_host_rdata, u0_mem_wdata;
  logic [ADDR_W-1:0] u0_mem_addr;

  int checks = 0;
  int fails  = 0;

  logic [DATA_W-1:0] ram [0:16383] = '{default: '0};

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  mac_se_fb_arbiter u_dut (
    .clk_in(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .vid_underrun(vid_underrun),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mac_se_fb_arbiter #(.STARVE_LIMIT(0)) u_dut0 (
    .clk_in(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(u0_vid_ack),
    .vid_rvalid(u0_vid_rvalid), .vid_rdata(u0_vid_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(u0_host_ready),
    .host_rvalid(u0_host_rvalid), .host_rdata(u0_host_rdata), .host_err(u0_host_err),
    .vid_underrun(u0_vid_underrun),
    .mem_en(u0_mem_en), .mem_we(u0_mem_we), .mem_addr(u0_mem_addr),
    .mem_wdata(u0_mem_wdata), .mem_rdata(16'h0000)
  );

  task automatic host_drive(input logic v, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_valid = v;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vid_req = 1'b1;
    host_drive(1'b1, 1'b0, 14'd1, 16'h0);
    #1;
    checks++;
    if ({vid_ack, host_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_grants: got %b expected 00", {vid_ack, host_ready});
    end
    @(negedge clk);
    reset   = 1'b0;
    vid_req = 1'b0;
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, host_err, vid_underrun,
         vid_rvalid, vid_rdata, host_rvalid, host_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected all 0",
               {mem_en, mem_we, mem_addr, mem_wdata, host_err, vid_underrun,
                vid_rvalid, vid_rdata, host_rvalid, host_rdata});
    end
  endtask

  task automatic test_write_read;
    @(negedge clk);
    host_drive(1'b1, 1'b1, 14'd100, 16'hA5A5);
    #1;
    checks++;
    if (host_ready !== 1'b1) begin
      fails++; $display("FAIL wr_ready: got %b expected 1", host_ready);
    end
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'd100, 16'hA5A5}) begin
      fails++;
      $display("FAIL wr_issue: got en=%b we=%b addr=%0d data=%h expected 1 1 100 a5a5",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    host_drive(1'b1, 1'b0, 14'd100, 16'h0);
    #1;
    checks++;
    if (host_ready !== 1'b1) begin
      fails++; $display("FAIL rd_ready: got %b expected 1", host_ready);
    end
    @(negedge clk);
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 14'd100}) begin
      fails++;
      $display("FAIL rd_issue: got en=%b we=%b addr=%0d expected 1 0 100", mem_en, mem_we, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b0) begin
      fails++; $display("FAIL rd_early: got rvalid=%b expected 0", host_rvalid);
    end
    @(negedge clk);
    checks++;
    if ({host_rvalid, host_rdata} !== {1'b1, 16'hA5A5}) begin
      fails++;
      $display("FAIL rd_return: got rvalid=%b data=%h expected 1 a5a5", host_rvalid, host_rdata);
    end
    @(negedge clk);
    checks++;
    if ({host_rvalid, host_rdata} !== {1'b0, 16'hA5A5}) begin
      fails++;
      $display("FAIL rd_hold: got rvalid=%b data=%h expected 0 a5a5", host_rvalid, host_rdata);
    end
  endtask

  task automatic test_reset_mid_read;
    logic seen;
    @(negedge clk);
    host_drive(1'b1, 1'b0, 14'd100, 16'h0);
    #1;
    checks++;
    if (host_ready !== 1'b1) begin
      fails++; $display("FAIL mid_ready: got %b expected 1", host_ready);
    end
    @(negedge clk);
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, host_err, vid_underrun,
         vid_rvalid, vid_rdata, host_rvalid, host_rdata} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b expected all 0",
               {mem_en, mem_we, mem_addr, mem_wdata, host_err, vid_underrun,
                vid_rvalid, vid_rdata, host_rvalid, host_rdata});
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | host_rvalid;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL mid_flush: got rvalid seen=%b expected 0", seen);
    end
  endtask

  task automatic test_starvation;
    logic exp_host;
    @(negedge clk);
    vid_req  = 1'b1;
    vid_addr = 14'd0;
    host_drive(1'b1, 1'b0, 14'd100, 16'h0);
    for (int i = 0; i < 27; i++) begin
      #1;
      exp_host = ((i % 9) == 8);
      checks++;
      if ({vid_ack, host_ready} !== {~exp_host, exp_host}) begin
        fails++;
        $display("FAIL starve_grant[%0d]: got ack=%b ready=%b expected %b %b",
                 i, vid_ack, host_ready, ~exp_host, exp_host);
      end
      @(negedge clk);
    end
    vid_req = 1'b0;
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    checks++;
    if (vid_underrun !== 1'b0) begin
      fails++; $display("FAIL starve_underrun: got %b expected 0", vid_underrun);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_out_of_range;
    @(negedge clk);
    host_drive(1'b1, 1'b0, 14'd10944, 16'h0);
    #1;
    checks++;
    if (host_ready !== 1'b1) begin
      fails++; $display("FAIL oor_ready: got %b expected 1", host_ready);
    end
    @(negedge clk);
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    checks++;
    if ({mem_en, host_err} !== 2'b01) begin
      fails++; $display("FAIL oor_issue: got en=%b err=%b expected 0 1", mem_en, host_err);
    end
    @(negedge clk);
    checks++;
    if (host_err !== 1'b0) begin
      fails++; $display("FAIL oor_err_pulse: got %b expected 0", host_err);
    end
    @(negedge clk);
    checks++;
    if ({host_rvalid, host_rdata} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL oor_return: got rvalid=%b data=%h expected 1 0000", host_rvalid, host_rdata);
    end
    host_drive(1'b1, 1'b1, 14'h3FFF, 16'h1234);
    @(negedge clk);
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    checks++;
    if ({mem_en, host_err} !== 2'b01) begin
      fails++; $display("FAIL oor_wr_issue: got en=%b err=%b expected 0 1", mem_en, host_err);
    end
    @(negedge clk);
    checks++;
    if (ram[16383] !== 16'h0000) begin
      fails++; $display("FAIL oor_wr_ram: got %h expected 0000", ram[16383]);
    end
    host_drive(1'b1, 1'b1, 14'd10943, 16'hBEEF);
    @(negedge clk);
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    checks++;
    if ({mem_en, mem_we, host_err, mem_addr} !== {1'b1, 1'b1, 1'b0, 14'd10943}) begin
      fails++;
      $display("FAIL last_word_wr: got en=%b we=%b err=%b addr=%0d expected 1 1 0 10943",
               mem_en, mem_we, host_err, mem_addr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_underrun;
    @(negedge clk);
    reset    = 1'b1;
    vid_req  = 1'b1;
    vid_addr = 14'd20;
    host_drive(1'b1, 1'b0, 14'd300, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({u0_vid_ack, u0_host_ready, u0_vid_underrun} !== 3'b010) begin
      fails++;
      $display("FAIL ur_start: got ack=%b ready=%b ur=%b expected 0 1 0",
               u0_vid_ack, u0_host_ready, u0_vid_underrun);
    end
    repeat (11) @(negedge clk);
    checks++;
    if (u0_vid_underrun !== 1'b0) begin
      fails++; $display("FAIL ur_before_deadline: got %b expected 0", u0_vid_underrun);
    end
    @(negedge clk);
    checks++;
    if (u0_vid_underrun !== 1'b1) begin
      fails++; $display("FAIL ur_at_deadline: got %b expected 1", u0_vid_underrun);
    end
    vid_req = 1'b0;
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    repeat (5) @(negedge clk);
    checks++;
    if (u0_vid_underrun !== 1'b1) begin
      fails++; $display("FAIL ur_sticky: got %b expected 1", u0_vid_underrun);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (u0_vid_underrun !== 1'b0) begin
      fails++; $display("FAIL ur_cleared: got %b expected 0", u0_vid_underrun);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] pat [4];
    int k;
    pat[0] = 16'h1111;
    pat[1] = 16'h2222;
    pat[2] = 16'h3333;
    pat[3] = 16'h4444;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      host_drive(1'b1, 1'b1, ADDR_W'(5 + i), pat[i]);
      @(negedge clk);
    end
    for (int j = 0; j < 8; j++) begin
      if (j < 4 && (j % 2) == 0) begin
        vid_req  = 1'b1;
        vid_addr = ADDR_W'(5 + j);
        host_drive(1'b0, 1'b0, 14'd0, 16'h0);
      end else if (j < 4) begin
        vid_req = 1'b0;
        host_drive(1'b1, 1'b0, ADDR_W'(5 + j), 16'h0);
      end else begin
        vid_req = 1'b0;
        host_drive(1'b0, 1'b0, 14'd0, 16'h0);
      end
      #1;
      if (j < 4) begin
        checks++;
        if ({vid_ack, host_ready} !== {((j % 2) == 0), ((j % 2) == 1)}) begin
          fails++;
          $display("FAIL b2b_grant[%0d]: got ack=%b ready=%b", j, vid_ack, host_ready);
        end
      end
      if (j >= 3 && j < 7) begin
        k = j - 3;
        checks++;
        if ({vid_rvalid, host_rvalid} !== {((k % 2) == 0), ((k % 2) == 1)}) begin
          fails++;
          $display("FAIL b2b_order[%0d]: got vid_rvalid=%b host_rvalid=%b", k, vid_rvalid, host_rvalid);
        end
        checks++;
        if (((k % 2) == 0) ? (vid_rdata !== pat[k]) : (host_rdata !== pat[k])) begin
          fails++;
          $display("FAIL b2b_data[%0d]: got vid=%h host=%h expected %h", k, vid_rdata, host_rdata, pat[k]);
        end
      end
      if (j == 7) begin
        checks++;
        if ({vid_rvalid, host_rvalid} !== 2'b00) begin
          fails++;
          $display("FAIL b2b_idle: got %b expected 00", {vid_rvalid, host_rvalid});
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    vid_req  = 1'b0;
    vid_addr = '0;
    host_drive(1'b0, 1'b0, 14'd0, 16'h0);
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_reset_mid_read();
    test_starvation();
    test_out_of_range();
    test_underrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
